// File: rtl/shift_issue_stage.sv
// shift_issue_stage
//   Registered issue stage feeding the combinational barrel shifter. Accepts
//   shift requests over valid/ready, decodes opcode and amount source into the
//   shifter's A/shamt/sel operands, and holds them in an output register (OR)
//   backed by a one-entry skid register (SR). in_ready depends only on the
//   registered SR valid flag, so out_ready never reaches in_ready
//   combinationally.
//
//   Optional feature macro: SHIFT_ISSUE_SAT_EN
//     When defined, register-sourced amounts >= 32 saturate: SLL/SRL produce 0
//     (sel 5, shamt 0), SRA produces sign fill (shamt 31), ROL/ROR wrap mod 32.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   in_op[2:0]            0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5-7 illegal
//   in_a[31:0]            value to shift
//   in_b[31:0]            register-sourced shift amount
//   in_imm[4:0]           immediate shift amount
//   in_use_imm            1 selects in_imm, 0 selects in_b
//   in_tag[TAG_W-1:0]     opaque request tag
//   out_valid / out_ready downstream handshake
//   out_a, out_shamt, out_sel, out_tag, out_err  decoded operands to shifter

module shift_issue_stage #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [4:0]       in_imm,
  input  logic             in_use_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_a,
  output logic [4:0]       out_shamt,
  output logic [2:0]       out_sel,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  typedef struct packed {
    logic [31:0]      a;
    logic [4:0]       shamt;
    logic [2:0]       sel;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  entry_t or_q, or_d;
  entry_t sr_q, sr_d;
  logic   or_valid_q, or_valid_d;
  logic   sr_valid_q, sr_valid_d;

  entry_t dec;
  logic   in_fire;
  logic   out_fire;

  // Decode happens before storage, so OR/SR always hold shifter-ready fields.
  always_comb begin
    dec.a     = in_a;
    dec.tag   = in_tag;
    dec.sel   = in_op;
    dec.err   = 1'b0;
    dec.shamt = in_use_imm ? in_imm : in_b[4:0];
    if (in_op > 3'd4) begin
      dec.sel   = 3'd5;
      dec.shamt = '0;
      dec.err   = 1'b1;
    end
`ifdef SHIFT_ISSUE_SAT_EN
    else if (!in_use_imm && (|in_b[31:5])) begin
      case (in_op)
        3'd0, 3'd1: begin
          dec.sel   = 3'd5;
          dec.shamt = '0;
        end
        3'd2:    dec.shamt = 5'd31;
        default: ;
      endcase
    end
`endif
  end

`ifndef SHIFT_ISSUE_SAT_EN
  // Upper amount bits only matter for saturation; tie them off here.
  logic unused_b_hi;
  always_comb unused_b_hi = |in_b[31:5];
`endif

  assign in_ready = !sr_valid_q;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = or_valid_q && out_ready;

  // SR full implies in_ready low, so an OR drain never coincides with both an
  // SR move and a new input.
  always_comb begin
    or_d       = or_q;
    sr_d       = sr_q;
    or_valid_d = or_valid_q;
    sr_valid_d = sr_valid_q;
    if (out_fire) begin
      if (sr_valid_q) begin
        or_d       = sr_q;
        sr_valid_d = 1'b0;
      end else if (in_fire) begin
        or_d = dec;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!or_valid_q) begin
        or_d       = dec;
        or_valid_d = 1'b1;
      end else begin
        sr_d       = dec;
        sr_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_q       <= '0;
      sr_q       <= '0;
      or_valid_q <= 1'b0;
      sr_valid_q <= 1'b0;
    end else begin
      or_q       <= or_d;
      sr_q       <= sr_d;
      or_valid_q <= or_valid_d;
      sr_valid_q <= sr_valid_d;
    end
  end

  assign out_valid = or_valid_q;
  assign out_a     = or_q.a;
  assign out_shamt = or_q.shamt;
  assign out_sel   = or_q.sel;
  assign out_tag   = or_q.tag;
  assign out_err   = or_q.err;

endmodule
